// File: rtl/csel_pkg.sv
// Shared configuration for the pipelined carry-select adder.
// Holds the default WIDTH/BLOCK, the group-count helper and the
// configuration legality check used at elaboration.
package csel_pkg;

    localparam int CSEL_WIDTH = 16;
    localparam int CSEL_BLOCK = 4;

    // Number of carry-select groups, which is also the pipeline depth.
    function automatic int csel_nblk(input int width, input int block);
        return width / block;
    endfunction

    // WIDTH must be a positive multiple of BLOCK and at least one group wide.
    function automatic bit csel_cfg_ok(input int width, input int block);
        return (block > 0) && (width >= block) && ((width % block) == 0);
    endfunction

endpackage

// File: rtl/csel_block.sv
// Purpose : one BLOCK-bit carry-select group (two ripple sums, carry picks one).
// Latency : combinational.
// Backpressure: none; pure logic.
// Ports   : SUM_O/C_O group sum and carry out; A_I/B_I group operands; C_I carry in.
module csel_block
    import csel_pkg::*;
#(
    parameter int BLOCK = CSEL_BLOCK
) (
    output logic [BLOCK-1:0] SUM_O,
    output logic             C_O,
    input  logic [BLOCK-1:0] A_I,
    input  logic [BLOCK-1:0] B_I,
    input  logic             C_I
);

    logic [BLOCK-1:0] sum0;
    logic [BLOCK-1:0] sum1;
    logic [BLOCK:0]   cy0;
    logic [BLOCK:0]   cy1;

    // Both ripple chains are computed up front so the late-arriving carry
    // only drives the final mux.
    always_comb begin
        sum0   = '0;
        sum1   = '0;
        cy0    = '0;
        cy1    = '0;
        cy1[0] = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            sum0[i]   = A_I[i] ^ B_I[i] ^ cy0[i];
            cy0[i+1]  = (A_I[i] & B_I[i]) | (cy0[i] & (A_I[i] ^ B_I[i]));
            sum1[i]   = A_I[i] ^ B_I[i] ^ cy1[i];
            cy1[i+1]  = (A_I[i] & B_I[i]) | (cy1[i] & (A_I[i] ^ B_I[i]));
        end
    end

    assign SUM_O = C_I ? sum1 : sum0;
    assign C_O   = C_I ? cy1[BLOCK] : cy0[BLOCK];

endmodule

// File: rtl/csel_adder_pipe.sv
// Purpose : pipelined carry-select adder, SUM = A+B+C_IN, one group resolved per stage.
// Latency : NBLK = WIDTH/BLOCK cycles from input transfer to OUT_VALID; 1 op/cycle.
// Backpressure: whole pipe stalls when OUT_VALID & ~OUT_READY; IN_READY drops the same cycle.
// Ports   : CLK/RST (sync, active high); IN_VALID/IN_READY with A, B, C_IN;
//           OUT_VALID/OUT_READY with SUM, C_OUT, OVF (all driven from final-stage flops).
module csel_adder_pipe
    import csel_pkg::*;
#(
    parameter int WIDTH = CSEL_WIDTH,
    parameter int BLOCK = CSEL_BLOCK
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             C_OUT,
    output logic             OVF
);

    localparam int NBLK = csel_nblk(WIDTH, BLOCK);

    if (!csel_cfg_ok(WIDTH, BLOCK)) begin : g_cfg_err
        $error("csel_adder_pipe: WIDTH must be a positive multiple of BLOCK");
    end

    // Stage k holds: valid, carry out of group k, sum bits of groups 0..k,
    // and the operands (upper groups still to be added are the ones consumed).
    logic [NBLK-1:0]             vld_q, vld_d;
    logic [NBLK-1:0]             cy_q,  cy_d;
    logic [NBLK-1:0][WIDTH-1:0]  a_q,   a_d;
    logic [NBLK-1:0][WIDTH-1:0]  b_q,   b_d;
    logic [NBLK-1:0][WIDTH-1:0]  sum_q, sum_d;
    logic                        ovf_q, ovf_d;

    logic [NBLK-1:0][BLOCK-1:0]  grp_sum;
    logic [NBLK-1:0]             grp_co;
    logic                        msb_cin;
    logic                        en;

    // One global advance: the pipe moves whenever the output slot is free or draining.
    assign en       = ~vld_q[NBLK-1] | OUT_READY;
    assign IN_READY = en | RST;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        logic [BLOCK-1:0] grp_a;
        logic [BLOCK-1:0] grp_b;
        logic             grp_ci;

        if (k == 0) begin : g_first
            assign grp_a  = A[0 +: BLOCK];
            assign grp_b  = B[0 +: BLOCK];
            assign grp_ci = C_IN;
        end else begin : g_rest
            assign grp_a  = a_q[k-1][k*BLOCK +: BLOCK];
            assign grp_b  = b_q[k-1][k*BLOCK +: BLOCK];
            assign grp_ci = cy_q[k-1];
        end

        csel_block #(
            .BLOCK (BLOCK)
        ) u_blk (
            .SUM_O (grp_sum[k]),
            .C_O   (grp_co[k]),
            .A_I   (grp_a),
            .B_I   (grp_b),
            .C_I   (grp_ci)
        );

        // Carry into the MSB recovered from the top group's operand and sum bits.
        if (k == NBLK - 1) begin : g_msb
            assign msb_cin = grp_a[BLOCK-1] ^ grp_b[BLOCK-1] ^ grp_sum[k][BLOCK-1];
        end
    end

    always_comb begin
        vld_d = vld_q;
        cy_d  = cy_q;
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        ovf_d = ovf_q;
        if (en) begin
            ovf_d    = msb_cin ^ grp_co[NBLK-1];
            cy_d     = grp_co;
            vld_d[0] = IN_VALID;
            a_d[0]   = A;
            b_d[0]   = B;
            sum_d[0] = '0;
            for (int k = 1; k < NBLK; k++) begin
                vld_d[k] = vld_q[k-1];
                a_d[k]   = a_q[k-1];
                b_d[k]   = b_q[k-1];
                sum_d[k] = sum_q[k-1];
            end
            for (int k = 0; k < NBLK; k++) begin
                sum_d[k][k*BLOCK +: BLOCK] = grp_sum[k];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q <= '0;
            cy_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            a_q   <= a_d;
            b_q   <= b_d;
            sum_q <= sum_d;
            ovf_q <= ovf_d;
        end
    end

    // Already-consumed operand groups (and the last stage's copy) have no reader.
    logic unused_opnd;
    assign unused_opnd = ^{a_q, b_q};

    assign OUT_VALID = vld_q[NBLK-1];
    assign SUM       = sum_q[NBLK-1];
    assign C_OUT     = cy_q[NBLK-1];
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Bench for csel_adder_pipe at WIDTH=16, BLOCK=4 (four-stage pipe).
// Directed vectors carry hand-computed results; streamed and random ops use a small reference adder.
// Every observed output transfer is matched against an in-order expectation queue.
module tb_csel_adder_pipe;

    logic        clk;
    logic        rst;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_ci;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;

    int          n_cmp;
    int          n_bad;
    int          n_in;
    int          n_out;
    logic [17:0] sb_q[$];

    csel_adder_pipe #(
        .WIDTH (16),
        .BLOCK (4)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_VALID  (in_vld),
        .IN_READY  (in_rdy),
        .A         (in_a),
        .B         (in_b),
        .C_IN      (in_ci),
        .OUT_VALID (out_vld),
        .OUT_READY (out_rdy),
        .SUM       (sum),
        .C_OUT     (c_out),
        .OVF       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    // Packed result {C_OUT, OVF, SUM}; overflow from operand/result sign rule.
    function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic ci);
        logic [16:0] s;
        logic        o;
        s = {1'b0, a} + {1'b0, b} + {16'b0, ci};
        o = (a[15] == b[15]) && (s[15] != a[15]);
        return {s[16], o, s[15:0]};
    endfunction

    // One cycle: drive inputs after the edge, account for transfers, advance to edge+1.
    task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic ordy, input logic [17:0] want);
        logic xin;
        logic xout;
        in_vld  = iv;
        in_a    = a;
        in_b    = b;
        in_ci   = ci;
        out_rdy = ordy;
        #1;
        xin  = iv && in_rdy && !rst;
        xout = out_vld && ordy && !rst;
        if (!ordy && out_vld && !rst) begin
            chk("stall_in_ready", 32'(in_rdy), 32'(0));
            if (sb_q.size() > 0) chk("stall_hold", 32'({c_out, ovf, sum}), 32'(sb_q[0]));
        end
        if (xout) begin
            if (sb_q.size() == 0) chk("spurious_out", 32'(out_vld), 32'(0));
            else                  chk("result", 32'({c_out, ovf, sum}), 32'(sb_q.pop_front()));
            n_out++;
        end
        if (xin) begin
            sb_q.push_back(want);
            n_in++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 16'h0, 16'h0, 1'b0, ordy, 18'h0);
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 40;
        while (sb_q.size() > 0 && budget > 0) begin
            idle(1'b1);
            budget--;
        end
        chk(tag, 32'(sb_q.size()), 32'(0));
    endtask

    // Back-to-back vectors: a, b, c_in, hand-computed {C_OUT, OVF, SUM}.
    logic [15:0] v_a   [8] = '{16'h0001, 16'h000F, 16'h00FF, 16'h0FFF,
                               16'h8000, 16'hFFFF, 16'h7FFF, 16'hA5A5};
    logic [15:0] v_b   [8] = '{16'h0001, 16'h0001, 16'h0001, 16'h0000,
                               16'h8000, 16'hFFFF, 16'h7FFF, 16'h5A5A};
    logic        v_ci  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [17:0] v_exp [8] = '{{2'b00, 16'h0002}, {2'b00, 16'h0010},
                               {2'b00, 16'h0100}, {2'b00, 16'h1000},
                               {2'b11, 16'h0000}, {2'b10, 16'hFFFF},
                               {2'b01, 16'hFFFF}, {2'b00, 16'hFFFF}};

    initial begin
        int base_in;
        int base_out;
        int budget;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        n_cmp   = 0;
        n_bad   = 0;
        n_in    = 0;
        n_out   = 0;
        rst     = 1'b1;
        in_vld  = 1'b0;
        in_a    = '0;
        in_b    = '0;
        in_ci   = 1'b0;
        out_rdy = 1'b1;

        // Reset held with live input traffic: outputs stay cleared, nothing queued.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1, 18'h0);
            chk("rst_out_valid", 32'(out_vld), 32'(0));
            chk("rst_sum",       32'(sum),     32'(0));
            chk("rst_c_out",     32'(c_out),   32'(0));
            chk("rst_ovf",       32'(ovf),     32'(0));
            chk("rst_in_ready",  32'(in_rdy),  32'(1));
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            chk("post_rst_quiet", 32'(out_vld), 32'(0));
        end

        // Single op: result appears exactly four edges after the transfer, for one cycle.
        step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1, {2'b00, 16'h5555});
        for (int i = 0; i < 3; i++) begin
            chk("lat_early", 32'(out_vld), 32'(0));
            idle(1'b1);
        end
        chk("lat_valid", 32'(out_vld), 32'(1));
        chk("lat_sum",   32'(sum),     32'h5555);
        chk("lat_c_out", 32'(c_out),   32'(0));
        chk("lat_ovf",   32'(ovf),     32'(0));
        idle(1'b1);
        chk("lat_one_cycle", 32'(out_vld), 32'(0));

        // Full carry chain and signed overflow.
        step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, {2'b10, 16'h0000});
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, {2'b01, 16'h8000});
        idle(1'b1);
        idle(1'b1);
        chk("wrap_valid", 32'(out_vld), 32'(1));
        chk("wrap_sum",   32'(sum),     32'h0000);
        chk("wrap_c_out", 32'(c_out),   32'(1));
        chk("wrap_ovf",   32'(ovf),     32'(0));
        idle(1'b1);
        chk("ovf_valid",  32'(out_vld), 32'(1));
        chk("ovf_sum",    32'(sum),     32'h8000);
        chk("ovf_c_out",  32'(c_out),   32'(0));
        chk("ovf_ovf",    32'(ovf),     32'(1));
        drain("chain_drain");

        // Eight back-to-back ops: outputs must occupy eight consecutive cycles.
        base_in  = n_in;
        base_out = n_out;
        for (int i = 0; i < 8; i++) step(1'b1, v_a[i], v_b[i], v_ci[i], 1'b1, v_exp[i]);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("stream_accepted", 32'(n_in - base_in),   32'(8));
        chk("stream_emitted",  32'(n_out - base_out), 32'(8));
        chk("stream_empty",    32'(sb_q.size()),      32'(0));

        // Backpressure: five stalled cycles mid-stream, then resume.
        base_in  = n_in;
        base_out = n_out;
        for (int i = 0; i < 6; i++) begin
            ra = 16'h1111 * 16'(i + 1);
            rb = 16'hF00D ^ 16'(i * 37);
            step(1'b1, ra, rb, i[0], 1'b1, ref_add(ra, rb, i[0]));
        end
        for (int i = 0; i < 5; i++) step(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0, ref_add(16'hDEAD, 16'hBEEF, 1'b1));
        for (int i = 0; i < 4; i++) begin
            ra = 16'h8421 + 16'(i);
            rb = 16'h7BDE - 16'(i);
            step(1'b1, ra, rb, 1'b1, 1'b1, ref_add(ra, rb, 1'b1));
        end
        drain("stall_drain");
        chk("stall_in_eq_out", 32'(n_in - base_in), 32'(n_out - base_out));
        chk("stall_accepted",  32'(n_in - base_in), 32'(10));

        // Reset with three ops in flight discards them all.
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0F0F, 16'h00F1, 1'b0, 1'b1, ref_add(16'h0F0F, 16'h00F1, 1'b0));
        rst = 1'b1;
        idle(1'b1);
        chk("midrst_valid", 32'(out_vld), 32'(0));
        sb_q.delete();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle(1'b1);
            chk("midrst_no_stale", 32'(out_vld), 32'(0));
        end

        // Random traffic with random valid/ready against the reference adder.
        base_in  = n_in;
        base_out = n_out;
        budget   = 60000;
        while ((n_in - base_in) < 10000 && budget > 0) begin
            ra = 16'($urandom());
            rb = 16'($urandom());
            rc = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 3) != 0), ra, rb, rc, 1'($urandom_range(0, 3) != 0),
                 ref_add(ra, rb, rc));
            budget--;
        end
        chk("rand_budget", 32'(n_in - base_in), 32'(10000));
        drain("rand_drain");
        chk("rand_in_eq_out", 32'(n_in - base_in), 32'(n_out - base_out));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
